// File: rtl/demux_pkg.sv
// Shared types and defaults for the credit-based demux dispatcher.
package demux_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_e;

    localparam int DEF_NUMOUT  = 16;
    localparam int DEF_DWIDTH  = 8;
    localparam int DEF_CREDITS = 4;

    // Enough bits to hold every value from 0 up to and including CREDITS.
    function automatic int cntWidth(input int credits);
        return $clog2(credits + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: scans req upward from ptr, wrapping at NUMOUT-1.
module rr_pick #(
    parameter int  NUMOUT = 16,
    localparam int SW     = $clog2(NUMOUT)
) (
    input  logic [NUMOUT-1:0] req,
    input  logic [SW-1:0]     ptr,
    output logic [SW-1:0]     gnt_idx,
    output logic              any
);

    int idx;

    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = 0; k < NUMOUT; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUMOUT) begin
                idx = idx - NUMOUT;
            end
            if (!any && req[idx]) begin
                any     = 1'b1;
                gnt_idx = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/demux_sched.sv
// Credit-based round-robin dispatcher feeding the demux sel/din/din_v inputs.
// Optional statistics counters are built when DEMUX_SCHED_STATS_EN is defined.
module demux_sched
    import demux_pkg::*;
#(
    parameter int  NUMOUT  = DEF_NUMOUT,
    parameter int  DWIDTH  = DEF_DWIDTH,
    parameter int  CREDITS = DEF_CREDITS,
    localparam int SW      = $clog2(NUMOUT),
    localparam int CW      = cntWidth(CREDITS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NUMOUT-1:0] cred_ret,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_v,
    output logic [SW-1:0]     out_sel,
    output logic              cred_err,
    output logic              busy
`ifdef DEMUX_SCHED_STATS_EN
   ,output logic [31:0]       dispatch_cnt
   ,output logic [31:0]       stall_cnt
`endif
);

    localparam logic [CW-1:0] CMAX = CW'(CREDITS);

    state_e state_q, state_d;

    logic [CW-1:0]     cnt_q [NUMOUT];
    logic [CW-1:0]     cnt_d [NUMOUT];
    logic [SW-1:0]     rrPtr_q, rrPtr_d;
    logic              credErr_q, credErr_d;
    logic              outV_q;
    logic [SW-1:0]     outSel_q;
    logic [DWIDTH-1:0] outData_q;

    logic [NUMOUT-1:0] haveCred;
    logic [NUMOUT-1:0] decVec;
    logic [SW-1:0]     gntIdx;
    logic              anyCred;
    logic              anyNext;
    logic              accept;

    // Selection only sees registered credits; same-cycle returns show up next cycle.
    always_comb begin
        for (int i = 0; i < NUMOUT; i++) begin
            haveCred[i] = (cnt_q[i] != '0);
        end
    end

    rr_pick #(.NUMOUT(NUMOUT)) u_pick (
        .req     (haveCred),
        .ptr     (rrPtr_q),
        .gnt_idx (gntIdx),
        .any     (anyCred)
    );

    assign accept = in_valid && in_ready;

    always_comb begin
        decVec = '0;
        if (accept) begin
            decVec[gntIdx] = 1'b1;
        end
    end

    always_comb begin
        rrPtr_d = rrPtr_q;
        if (accept) begin
            rrPtr_d = (gntIdx == SW'(NUMOUT - 1)) ? '0 : gntIdx + 1'b1;
        end
    end

    // A return and a dispatch on the same lane cancel; a return to a full lane saturates and flags.
    always_comb begin
        credErr_d = credErr_q;
        anyNext   = 1'b0;
        for (int i = 0; i < NUMOUT; i++) begin
            cnt_d[i] = cnt_q[i];
            if (cred_ret[i] && !decVec[i]) begin
                if (cnt_q[i] == CMAX) begin
                    credErr_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (decVec[i] && !cred_ret[i]) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
            if (cnt_d[i] != '0) begin
                anyNext = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable)       state_d = IDLE;
                else if (!anyCred) state_d = STALL;
            end
            STALL: begin
                if (!enable)      state_d = IDLE;
                else if (anyNext) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == RUN) && anyCred;
        busy     = (state_q != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUMOUT; i++) begin
                cnt_q[i] <= CMAX;
            end
            rrPtr_q   <= '0;
            credErr_q <= 1'b0;
            outV_q    <= 1'b0;
            outSel_q  <= '0;
            outData_q <= '0;
        end else begin
            for (int i = 0; i < NUMOUT; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rrPtr_q   <= rrPtr_d;
            credErr_q <= credErr_d;
            outV_q    <= accept;
            if (accept) begin
                outSel_q  <= gntIdx;
                outData_q <= in_data;
            end
        end
    end

    assign out_v    = outV_q;
    assign out_sel  = outSel_q;
    assign out_data = outData_q;
    assign cred_err = credErr_q;

`ifdef DEMUX_SCHED_STATS_EN
    logic [31:0] dispatchCnt_q;
    logic [31:0] stallCnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dispatchCnt_q <= '0;
            stallCnt_q    <= '0;
        end else begin
            if (outV_q) begin
                dispatchCnt_q <= dispatchCnt_q + 32'd1;
            end
            if (state_q == STALL) begin
                stallCnt_q <= stallCnt_q + 32'd1;
            end
        end
    end

    assign dispatch_cnt = dispatchCnt_q;
    assign stall_cnt    = stallCnt_q;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Directed table-driven bench for demux_sched with NUMOUT=4, CREDITS=2.
module tb_demux_sched;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] cred_ret;
    logic [7:0] out_data;
    logic       out_v;
    logic [1:0] out_sel;
    logic       cred_err;
    logic       busy;
`ifdef DEMUX_SCHED_STATS_EN
    logic [31:0] dispatch_cnt;
    logic [31:0] stall_cnt;
`endif

    int total;
    int bad;

    demux_sched #(.NUMOUT(4), .DWIDTH(8), .CREDITS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .cred_ret (cred_ret),
        .out_data (out_data),
        .out_v    (out_v),
        .out_sel  (out_sel),
        .cred_err (cred_err),
        .busy     (busy)
`ifdef DEMUX_SCHED_STATS_EN
       ,.dispatch_cnt (dispatch_cnt)
       ,.stall_cnt    (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] data;
        logic [3:0] cr;
        logic       expReady;
        logic       expBusy;
        logic       expV;
        logic [1:0] expSel;
        logic [7:0] expData;
    } vec_t;

    vec_t vecs [13];

    task automatic applyStimulus(input logic en, input logic v, input logic [7:0] d, input logic [3:0] cr);
        enable   = en;
        in_valid = v;
        in_data  = d;
        cred_ret = cr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic step(input logic en, input logic v, input logic [7:0] d, input logic [3:0] cr);
        applyStimulus(en, v, d, cr);
        tick();
    endtask

    task automatic checkBeat(input string name, input logic [1:0] sel, input logic [7:0] d);
        checkOutput({name, "_v"}, 32'(out_v), 32'd1);
        checkOutput({name, "_sel"}, 32'(out_sel), 32'(sel));
        checkOutput({name, "_data"}, 32'(out_data), 32'(d));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 4'h0);

        // Full-credit sweep, drain to STALL, then one returned credit on lane 2.
        vecs[0]  = '{1, 1, 8'h10, 4'h0, 0, 0, 0, 2'd0, 8'h00};
        vecs[1]  = '{1, 1, 8'h11, 4'h0, 1, 1, 1, 2'd0, 8'h11};
        vecs[2]  = '{1, 1, 8'h12, 4'h0, 1, 1, 1, 2'd1, 8'h12};
        vecs[3]  = '{1, 1, 8'h13, 4'h0, 1, 1, 1, 2'd2, 8'h13};
        vecs[4]  = '{1, 1, 8'h14, 4'h0, 1, 1, 1, 2'd3, 8'h14};
        vecs[5]  = '{1, 1, 8'h15, 4'h0, 1, 1, 1, 2'd0, 8'h15};
        vecs[6]  = '{1, 1, 8'h16, 4'h0, 1, 1, 1, 2'd1, 8'h16};
        vecs[7]  = '{1, 1, 8'h17, 4'h0, 1, 1, 1, 2'd2, 8'h17};
        vecs[8]  = '{1, 1, 8'h18, 4'h0, 1, 1, 1, 2'd3, 8'h18};
        vecs[9]  = '{1, 1, 8'h19, 4'h0, 0, 1, 0, 2'd3, 8'h18};
        vecs[10] = '{1, 1, 8'h20, 4'h4, 0, 1, 0, 2'd3, 8'h18};
        vecs[11] = '{1, 1, 8'h21, 4'h0, 1, 1, 1, 2'd2, 8'h21};
        vecs[12] = '{1, 1, 8'h22, 4'h0, 0, 1, 0, 2'd2, 8'h21};

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_out_v", 32'(out_v), 32'd0);
        checkOutput("rst_out_sel", 32'(out_sel), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'd0);
        checkOutput("rst_cred_err", 32'(cred_err), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].en, vecs[i].v, vecs[i].data, vecs[i].cr);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].expBusy));
            tick();
            checkOutput($sformatf("vec%0d_out_v", i), 32'(out_v), 32'(vecs[i].expV));
            checkOutput($sformatf("vec%0d_out_sel", i), 32'(out_sel), 32'(vecs[i].expSel));
            checkOutput($sformatf("vec%0d_out_data", i), 32'(out_data), 32'(vecs[i].expData));
        end

        // Lane 1 left empty with the pointer parked on it: grant must skip to lane 2.
        step(1, 0, 8'h00, 4'b1101);
        step(1, 0, 8'h00, 4'b1101);
        step(1, 1, 8'h30, 4'b0000);
        checkBeat("skip_pre0", 2'd3, 8'h30);
        step(1, 1, 8'h31, 4'b0000);
        checkBeat("skip_pre1", 2'd0, 8'h31);
        step(1, 0, 8'h00, 4'b1001);
        checkOutput("skip_idle_v", 32'(out_v), 32'd0);
        step(1, 1, 8'h32, 4'b0000);
        checkBeat("skip_lane1", 2'd2, 8'h32);
        step(1, 1, 8'h33, 4'b0000);
        checkBeat("skip_ptr3", 2'd3, 8'h33);

        // Lane 0 at one credit gets a dispatch and a return together.
        step(1, 1, 8'h40, 4'b0000);
        checkBeat("net_a", 2'd0, 8'h40);
        step(1, 1, 8'h41, 4'b0000);
        checkBeat("net_b", 2'd2, 8'h41);
        step(1, 1, 8'h42, 4'b0000);
        checkBeat("net_c", 2'd3, 8'h42);
        step(1, 1, 8'h43, 4'b0001);
        checkBeat("net_same", 2'd0, 8'h43);
        checkOutput("net_cred_err", 32'(cred_err), 32'd0);
        applyStimulus(1, 1, 8'h44, 4'b0000);
        #1;
        checkOutput("net_kept_ready", 32'(in_ready), 32'd1);
        tick();
        checkBeat("net_kept", 2'd0, 8'h44);
        applyStimulus(1, 1, 8'h45, 4'b0000);
        #1;
        checkOutput("net_drained_ready", 32'(in_ready), 32'd0);
        tick();
        checkOutput("net_drained_v", 32'(out_v), 32'd0);

        // Over-return on lane 3 saturates and latches cred_err.
        step(1, 0, 8'h00, 4'b1000);
        step(1, 0, 8'h00, 4'b1000);
        checkOutput("sat_err_before", 32'(cred_err), 32'd0);
        step(1, 0, 8'h00, 4'b1000);
        checkOutput("sat_err_set", 32'(cred_err), 32'd1);
        step(1, 1, 8'h50, 4'b0000);
        checkBeat("sat_b0", 2'd3, 8'h50);
        step(1, 1, 8'h51, 4'b0000);
        checkBeat("sat_b1", 2'd3, 8'h51);
        applyStimulus(1, 1, 8'h52, 4'b0000);
        #1;
        checkOutput("sat_no_third", 32'(in_ready), 32'd0);
        tick();
        checkOutput("sat_err_held", 32'(cred_err), 32'd1);

        // Enable dropped in the same cycle as an accept.
        step(1, 0, 8'h00, 4'b0001);
        applyStimulus(0, 1, 8'hA5, 4'b0000);
        #1;
        checkOutput("endrop_ready", 32'(in_ready), 32'd1);
        tick();
        checkBeat("endrop_beat", 2'd0, 8'hA5);
        applyStimulus(0, 1, 8'h77, 4'b0000);
        #1;
        checkOutput("endrop_ready_after", 32'(in_ready), 32'd0);
        checkOutput("endrop_busy_after", 32'(busy), 32'd0);
        tick();
        checkOutput("endrop_v_after", 32'(out_v), 32'd0);
        checkOutput("endrop_data_hold", 32'(out_data), 32'hA5);

        // Returns while IDLE are still counted.
        step(0, 0, 8'h00, 4'b0001);
        step(1, 1, 8'h60, 4'b0000);
        checkOutput("idle_ret_v", 32'(out_v), 32'd0);
        step(1, 1, 8'h61, 4'b0000);
        checkBeat("idle_ret_beat", 2'd0, 8'h61);

        // Asynchronous reset mid-cycle.
        applyStimulus(1, 1, 8'h62, 4'b0000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_out_v", 32'(out_v), 32'd0);
        checkOutput("arst_out_data", 32'(out_data), 32'd0);
        checkOutput("arst_out_sel", 32'(out_sel), 32'd0);
        checkOutput("arst_cred_err", 32'(cred_err), 32'd0);
        checkOutput("arst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("arst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 8'h70, 4'b0000);
        step(1, 1, 8'h71, 4'b0000);
        checkBeat("post_rst", 2'd0, 8'h71);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
Credit-based round-robin dispatcher that drives the select/valid/data inputs of the team's `demux` block (sel, din, din_v).
- Accepts a single valid/ready input stream and steers each beat to one of NUMOUT output lanes.
- Each lane's downstream consumer returns credits; no lane is sent a beat without a credit.
- Sits directly upstream of `demux`; `demux` then adds its own one-cycle register stage.

Parameters:
NUMOUT, 16, number of output lanes (≥2); sel width is $clog2(NUMOUT).
DWIDTH, 8, data width per beat.
CREDITS, 4, initial and maximum credits per lane (≥1); counter width CW = $clog2(CREDITS+1).

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
enable  in  1  level; 1 = dispatching allowed.
in_data  in  DWIDTH  input beat.
in_valid  in  1  input beat valid.
in_ready  out  1  block can accept a beat this cycle.
cred_ret  in  NUMOUT  per-lane one-cycle credit-return pulses; multiple bits may be set in one cycle.
out_data  out  DWIDTH  to demux din.
out_v  out  1  to demux din_v.
out_sel  out  $clog2(NUMOUT)  to demux sel.
cred_err  out  1  sticky; a credit was returned to a lane already at CREDITS.
busy  out  1  high in RUN or STALL.

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE; every credit counter = CREDITS; rr pointer = 0.
  - out_data = 0, out_v = 0, out_sel = 0, cred_err = 0, in_ready = 0.
- States:
  - IDLE: in_ready = 0. Go to RUN when enable = 1.
  - RUN: in_ready = 1 iff at least one lane has a registered credit > 0.
    - If enable = 0, go to IDLE.
    - Else if no lane has credit, go to STALL.
  - STALL: in_ready = 0.
    - If enable = 0, go to IDLE.
    - Else if any counter > 0 (counters are evaluated after the current cycle's returns are applied), go to RUN next cycle.
- Grant selection (combinational):
  - Candidate = first lane with credit > 0, scanning from the rr pointer upward with wrap at NUMOUT-1 → 0.
  - Credit visibility: a return arriving in the same cycle is not visible to selection until the next cycle.
- Accept (in_valid & in_ready):
  - Next cycle: out_v = 1, out_sel = candidate, out_data = in_data.
  - Candidate's counter decrements by 1; rr pointer = (candidate + 1) mod NUMOUT.
  - Latency in → out: 1 cycle. Sustained 1 beat/cycle while credits last.
- No accept: next cycle out_v = 0; out_sel and out_data hold their previous values.
- Credit returns:
  - Each set cred_ret bit increments its lane's counter.
  - Same-cycle decrement and return on one lane: net 0.
  - Return to a lane at CREDITS with no same-cycle decrement: counter saturates, cred_err sets. cred_err clears only on reset.
- enable deasserted mid-stream:
  - A beat accepted in that same cycle still issues next cycle.
  - No further accepts; counters keep tracking returns while IDLE.
- Arithmetic: counters unsigned CW bits; never below 0 (decrement only on lanes with credit > 0).
- busy = (state != IDLE).

Optional Feature:
Macro DEMUX_SCHED_STATS_EN.
- Defined:
  - Adds output dispatch_cnt [31:0]: counts out_v beats, wraps at 2^32, reset 0.
  - Adds output stall_cnt [31:0]: counts cycles in STALL, wraps at 2^32, reset 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - state enum {IDLE, RUN, STALL}, 2 bits.
  - Default constants for NUMOUT, DWIDTH, CREDITS.
  - Function computing counter width from CREDITS.
- Sub-module rr_pick: combinational round-robin first-one finder.
  - Inputs: req[NUMOUT], ptr.
  - Outputs: gnt_idx, any.
  - Reusable by later arbiters.

Test Plan:
- Reset then enable=1, in_valid=1 constant, no returns, NUMOUT=4, CREDITS=2 → out_sel sequence 0,1,2,3,0,1,2,3, one cycle after each accept. Then in_ready=0, state STALL, busy=1.
- From STALL, pulse cred_ret=4'b0100 → back to RUN after one cycle; next beat goes to lane 2; in_ready drops again after it.
- Lane 1 credit=0, others full, pointer at 1 → grant skips to lane 2; pointer becomes 3.
- Same-cycle dispatch to lane 0 and cred_ret[0]=1 with lane 0 at 1 credit → counter stays 1; cred_err stays 0.
- cred_ret[3]=1 while lane 3 is at CREDITS → counter stays CREDITS; cred_err=1 and held until rst_n pulse.
- enable dropped in the same cycle as an accept of in_data=8'hA5 → next cycle out_v=1, out_data=8'hA5; following cycle out_v=0, in_ready=0, busy=0. Separately, rst_n asserted mid-stream → all outputs zero immediately (asynchronously).
